pipelined_shifter_unit: RTL and testbench

- Parametrised, pipelined operand-2 shifter for the ARM-style datapath. Sits between register read and the ALU.
- Performs LSL/LSR/ASR/ROR/RRX on a register operand, with the amount taken either from the instruction or from a register.
- Also performs the rotated-immediate expansion.
- Handles a valid/ready stream with backpressure. Shifter carry-out is registered alongside the result.

---
 rtl/pipelined_shifter_unit.sv | 197 +++++++++++++++++++
 tb/tb_pipelined_shifter_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter_unit.sv
// pipelined_shifter_unit: ARM-style operand-2 shifter (LSL/LSR/ASR/ROR/RRX, rotated immediate) on a valid/ready pipe.
// Define SHIFTER_FLAGS_EN to add the registered out_Zero and out_Neg result flags.
module pipelined_shifter_unit #(
    parameter int WIDTH    = 32,
    parameter int LATENCY  = 2,
    parameter int IMM_BITS = 8
) (
    input  logic                     in_Clk,
    input  logic                     in_Rst_N,
    input  logic                     in_Flush,
    input  logic                     in_Valid,
    output logic                     out_Ready,
    input  logic                     in_Imm_op,
    input  logic [1:0]               in_Shift_type,
    input  logic                     in_Amt_is_reg,
    input  logic [$clog2(WIDTH)-1:0] in_Shift_imm,
    input  logic [3:0]               in_Rot,
    input  logic [WIDTH-1:0]         in_Rs_val,
    input  logic [WIDTH-1:0]         in_Val,
    input  logic                     in_C_flag,
    output logic                     out_Valid,
    input  logic                     in_Ready,
    output logic [WIDTH-1:0]         out_Result,
    output logic                     out_Carry
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic                     out_Zero,
    output logic                     out_Neg
`endif
);
    localparam int AW = $clog2(WIDTH);
    localparam logic [8:0] W9 = 9'(WIDTH);

    // Every operand is reduced to one of these kinds so the shift stage never re-examines amounts.
    typedef enum logic [3:0] {
        K_PASS, K_LSL, K_LSR, K_ASR, K_ROR, K_IMM,
        K_ZLO, K_ZHI, K_Z0, K_SIGN, K_RRX, K_RORW
    } kind_e;

    kind_e            shift_kind;
    kind_e            dec_kind;
    logic [AW-1:0]    dec_amt;
    logic [WIDTH-1:0] dec_val;
    logic [7:0]       rs_amt;
    logic [8:0]       rs_amt9;
    logic             accept;

    assign rs_amt     = in_Rs_val[7:0];
    assign rs_amt9    = {1'b0, rs_amt};
    assign accept     = in_Valid && out_Ready;
    assign shift_kind = (in_Shift_type == 2'b00) ? K_LSL :
                        (in_Shift_type == 2'b01) ? K_LSR :
                        (in_Shift_type == 2'b10) ? K_ASR : K_ROR;

    always_comb begin
        dec_kind = K_PASS;
        dec_amt  = '0;
        dec_val  = in_Val;
        if (in_Imm_op) begin
            dec_val  = WIDTH'(in_Val[IMM_BITS-1:0]);
            dec_amt  = AW'({in_Rot, 1'b0});
            dec_kind = (in_Rot == 4'd0) ? K_PASS : K_IMM;
        end else if (!in_Amt_is_reg) begin
            dec_amt  = in_Shift_imm;
            dec_kind = (in_Shift_imm != '0)      ? shift_kind :
                       (in_Shift_type == 2'b00) ? K_PASS :
                       (in_Shift_type == 2'b01) ? K_ZHI :
                       (in_Shift_type == 2'b10) ? K_SIGN : K_RRX;
        end else begin
            dec_amt  = rs_amt[AW-1:0];
            dec_kind = (rs_amt == 8'd0)          ? K_PASS :
                       (in_Shift_type == 2'b11) ? ((rs_amt[AW-1:0] == '0) ? K_RORW : K_ROR) :
                       (rs_amt9 < W9)           ? shift_kind :
                       (in_Shift_type == 2'b10) ? K_SIGN :
                       (rs_amt9 > W9)           ? K_Z0 :
                       (in_Shift_type == 2'b00) ? K_ZLO : K_ZHI;
        end
    end

    kind_e            st_kind;
    logic [AW-1:0]    st_amt;
    logic [WIDTH-1:0] st_val;
    logic             st_c;
    logic             st_vld;
    logic             out_vld_q, out_vld_d, out_adv, out_load;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;

    assign out_adv   = !out_vld_q || in_Ready;
    assign out_vld_d = in_Flush ? 1'b0 : out_adv ? st_vld : out_vld_q;
    assign out_load  = out_adv && st_vld;

    generate
        if (LATENCY == 2) begin : g_two
            logic             s1_vld_q, s1_vld_d;
            kind_e            s1_kind_q;
            logic [AW-1:0]    s1_amt_q;
            logic [WIDTH-1:0] s1_val_q;
            logic             s1_c_q;
            assign s1_vld_d  = in_Flush ? 1'b0 : out_Ready ? accept : s1_vld_q;
            assign out_Ready = !s1_vld_q || out_adv;
            assign st_vld    = s1_vld_q;
            assign st_kind   = s1_kind_q;
            assign st_amt    = s1_amt_q;
            assign st_val    = s1_val_q;
            assign st_c      = s1_c_q;
            always_ff @(posedge in_Clk or negedge in_Rst_N) begin
                if (!in_Rst_N) begin
                    s1_vld_q  <= 1'b0;
                    s1_kind_q <= K_PASS;
                    s1_amt_q  <= '0;
                    s1_val_q  <= '0;
                    s1_c_q    <= 1'b0;
                end else begin
                    s1_vld_q <= s1_vld_d;
                    if (accept) begin
                        s1_kind_q <= dec_kind;
                        s1_amt_q  <= dec_amt;
                        s1_val_q  <= dec_val;
                        s1_c_q    <= in_C_flag;
                    end
                end
            end
        end else begin : g_one
            assign out_Ready = out_adv;
            assign st_vld    = accept;
            assign st_kind   = dec_kind;
            assign st_amt    = dec_amt;
            assign st_val    = dec_val;
            assign st_c      = in_C_flag;
        end
    endgenerate

    logic [WIDTH:0]        lsl_x, rsh_x;
    logic signed [WIDTH:0] asr_x;
    logic [2*WIDTH-1:0]    ror_x;
    logic [WIDTH-1:0]      ex_res;
    logic                  ex_c;
    logic                  unused_bits;

    // The extra bit on each shifted vector catches the last bit shifted out, which is the carry.
    always_comb begin
        lsl_x  = {1'b0, st_val} << st_amt;
        rsh_x  = {st_val, 1'b0} >> st_amt;
        asr_x  = $signed({st_val, 1'b0}) >>> st_amt;
        ror_x  = {st_val, st_val} >> st_amt;
        ex_res = st_val;
        ex_c   = st_c;
        case (st_kind)
            K_LSL:   begin ex_res = lsl_x[WIDTH-1:0];          ex_c = lsl_x[WIDTH];     end
            K_LSR:   begin ex_res = rsh_x[WIDTH:1];            ex_c = rsh_x[0];         end
            K_ASR:   begin ex_res = asr_x[WIDTH:1];            ex_c = asr_x[0];         end
            K_ROR:   begin ex_res = ror_x[WIDTH-1:0];          ex_c = rsh_x[0];         end
            K_IMM:   begin ex_res = ror_x[WIDTH-1:0];          ex_c = ror_x[WIDTH-1];   end
            K_ZLO:   begin ex_res = '0;                        ex_c = st_val[0];        end
            K_ZHI:   begin ex_res = '0;                        ex_c = st_val[WIDTH-1];  end
            K_Z0:    begin ex_res = '0;                        ex_c = 1'b0;             end
            K_SIGN:  begin ex_res = {WIDTH{st_val[WIDTH-1]}};  ex_c = st_val[WIDTH-1];  end
            K_RRX:   begin ex_res = {st_c, st_val[WIDTH-1:1]}; ex_c = st_val[0];        end
            K_RORW:  begin ex_res = st_val;                    ex_c = st_val[WIDTH-1];  end
            default: begin ex_res = st_val;                    ex_c = st_c;             end
        endcase
    end

    assign unused_bits = ^{in_Rs_val[WIDTH-1:8], ror_x[2*WIDTH-1:WIDTH]};

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            out_vld_q <= 1'b0;
            res_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            if (out_load) begin
                res_q   <= ex_res;
                carry_q <= ex_c;
            end
        end
    end

    assign out_Valid  = out_vld_q;
    assign out_Result = res_q;
    assign out_Carry  = carry_q;

`ifdef SHIFTER_FLAGS_EN
    logic zero_q;
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            zero_q <= 1'b0;
        end else if (out_load) begin
            zero_q <= (ex_res == '0);
        end
    end
    assign out_Zero = zero_q;
    assign out_Neg  = res_q[WIDTH-1];
`endif
endmodule

// File: tb/tb_pipelined_shifter_unit.sv
// tb_pipelined_shifter_unit: directed vectors for the pipelined operand-2 shifter, default 32-bit, 2-stage build.
module tb_pipelined_shifter_unit;
    logic        in_Clk = 1'b0;
    logic        in_Rst_N;
    logic        in_Flush;
    logic        in_Valid;
    logic        out_Ready;
    logic        in_Imm_op;
    logic [1:0]  in_Shift_type;
    logic        in_Amt_is_reg;
    logic [4:0]  in_Shift_imm;
    logic [3:0]  in_Rot;
    logic [31:0] in_Rs_val;
    logic [31:0] in_Val;
    logic        in_C_flag;
    logic        out_Valid;
    logic        in_Ready;
    logic [31:0] out_Result;
    logic        out_Carry;
`ifdef SHIFTER_FLAGS_EN
    logic        out_Zero;
    logic        out_Neg;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipelined_shifter_unit #(.WIDTH(32), .LATENCY(2), .IMM_BITS(8)) dut (
        .in_Clk(in_Clk), .in_Rst_N(in_Rst_N), .in_Flush(in_Flush),
        .in_Valid(in_Valid), .out_Ready(out_Ready), .in_Imm_op(in_Imm_op),
        .in_Shift_type(in_Shift_type), .in_Amt_is_reg(in_Amt_is_reg),
        .in_Shift_imm(in_Shift_imm), .in_Rot(in_Rot), .in_Rs_val(in_Rs_val),
        .in_Val(in_Val), .in_C_flag(in_C_flag), .out_Valid(out_Valid),
        .in_Ready(in_Ready), .out_Result(out_Result), .out_Carry(out_Carry)
`ifdef SHIFTER_FLAGS_EN
        , .out_Zero(out_Zero), .out_Neg(out_Neg)
`endif
    );

    always #5 in_Clk = ~in_Clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge in_Clk);
        #1;
    endtask

    task automatic set_op(input logic imm, input logic [1:0] typ, input logic areg, input logic [4:0] simm,
                          input logic [3:0] rot, input logic [31:0] rs, input logic [31:0] val, input logic c);
        in_Imm_op     = imm;
        in_Shift_type = typ;
        in_Amt_is_reg = areg;
        in_Shift_imm  = simm;
        in_Rot        = rot;
        in_Rs_val     = rs;
        in_Val        = val;
        in_C_flag     = c;
    endtask

    task automatic run_op(input string tag, input logic imm, input logic [1:0] typ, input logic areg,
                          input logic [4:0] simm, input logic [3:0] rot, input logic [31:0] rs,
                          input logic [31:0] val, input logic c, input logic [31:0] er, input logic ec);
        int n;
        set_op(imm, typ, areg, simm, rot, rs, val, c);
        in_Valid = 1'b1;
        #1;
        n = 0;
        while (!out_Ready && n < 10) begin tick; n++; end
        tick;
        in_Valid = 1'b0;
        n = 0;
        while (!out_Valid && n < 10) begin tick; n++; end
        chk({tag, "_v"}, out_Valid, 1);
        chk({tag, "_r"}, out_Result, er);
        chk({tag, "_c"}, out_Carry, ec);
    endtask

    initial begin
        int sent, recv, hits;
        logic acc, take;
        in_Rst_N = 1'b0;
        in_Flush = 1'b0;
        in_Valid = 1'b0;
        in_Ready = 1'b1;
        set_op(0, 2'b00, 0, 5'd0, 4'd0, 32'd0, 32'd0, 0);
        tick;
        tick;
        chk("rst_v", out_Valid, 0);
        chk("rst_r", out_Result, 0);
        chk("rst_c", out_Carry, 0);
        in_Rst_N = 1'b1;
        tick;
        chk("rst_rdy", out_Ready, 1);

        // LSR #0 acts as LSR #32, with the two-cycle latency checked explicitly
        set_op(0, 2'b01, 0, 5'd0, 4'd0, 32'd0, 32'h8000_0001, 0);
        in_Valid = 1'b1;
        #1;
        chk("t1_rdy", out_Ready, 1);
        tick;
        in_Valid = 1'b0;
        chk("t1_lat1", out_Valid, 0);
        tick;
        chk("t1_lat2", out_Valid, 1);
        chk("t1_r", out_Result, 32'h0);
        chk("t1_c", out_Carry, 1);
`ifdef SHIFTER_FLAGS_EN
        chk("t1_z", out_Zero, 1);
`endif

        run_op("asr_r40",  0, 2'b10, 1, 5'd0, 4'd0, 32'h28,  32'h8000_0000, 0, 32'hFFFF_FFFF, 1);
        run_op("lsl_r260", 0, 2'b00, 1, 5'd0, 4'd0, 32'h104, 32'h1000_0001, 0, 32'h0000_0010, 1);
        run_op("rrx",      0, 2'b11, 0, 5'd0, 4'd0, 32'h0,   32'h0000_0003, 1, 32'h8000_0001, 1);
        run_op("ror_r32",  0, 2'b11, 1, 5'd0, 4'd0, 32'h20,  32'h8000_0000, 0, 32'h8000_0000, 1);
        run_op("imm_rot4", 1, 2'b10, 1, 5'd7, 4'd4, 32'h3,   32'hABCD_EFFF, 0, 32'hFF00_0000, 1);
        run_op("imm_rot0", 1, 2'b01, 1, 5'd3, 4'd0, 32'h9,   32'h1234_56FF, 0, 32'h0000_00FF, 0);
        run_op("lsl_i0",   0, 2'b00, 0, 5'd0, 4'd0, 32'h0,   32'h1234_5678, 1, 32'h1234_5678, 1);
        run_op("asr_i0",   0, 2'b10, 0, 5'd0, 4'd0, 32'h0,   32'h4000_0000, 1, 32'h0000_0000, 0);
        run_op("asr_i4",   0, 2'b10, 0, 5'd4, 4'd0, 32'h0,   32'h8000_0010, 0, 32'hF800_0001, 0);
        run_op("ror_i8",   0, 2'b11, 0, 5'd8, 4'd0, 32'h0,   32'h1234_5678, 1, 32'h7812_3456, 0);
        run_op("lsr_i1",   0, 2'b01, 0, 5'd1, 4'd0, 32'h0,   32'h0000_0003, 0, 32'h0000_0001, 1);
        run_op("lsl_r32",  0, 2'b00, 1, 5'd0, 4'd0, 32'h20,  32'h0000_0001, 0, 32'h0000_0000, 1);
        run_op("lsl_r33",  0, 2'b00, 1, 5'd0, 4'd0, 32'h21,  32'hFFFF_FFFF, 1, 32'h0000_0000, 0);
        run_op("lsr_r32",  0, 2'b01, 1, 5'd0, 4'd0, 32'h20,  32'h8000_0000, 0, 32'h0000_0000, 1);
        run_op("lsr_r4",   0, 2'b01, 1, 5'd0, 4'd0, 32'h4,   32'h0000_001F, 0, 32'h0000_0001, 1);
        run_op("asr_r0",   0, 2'b10, 1, 5'd0, 4'd0, 32'h100, 32'h8000_0000, 1, 32'h8000_0000, 1);
        run_op("ror_r36",  0, 2'b11, 1, 5'd0, 4'd0, 32'h24,  32'h0000_00F8, 0, 32'h8000_000F, 1);
        tick;

        // six back-to-back LSL #k of 1 with a three-cycle downstream stall
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            set_op(0, 2'b00, 0, 5'(sent + 1), 4'd0, 32'd0, 32'h1, 0);
            in_Valid = (sent < 6);
            in_Ready = !(cyc >= 3 && cyc <= 5);
            #1;
            chk("bp_rdy", out_Ready, (sent - recv < 2) || in_Ready);
            if (out_Valid) begin
                chk("bp_res", out_Result, 32'h1 << (recv + 1));
                chk("bp_c", out_Carry, 0);
            end
            acc  = in_Valid && out_Ready;
            take = out_Valid && in_Ready;
            tick;
            sent += int'(acc);
            recv += int'(take);
        end
        in_Valid = 1'b0;
        in_Ready = 1'b1;
        chk("bp_sent", sent, 6);
        chk("bp_recv", recv, 6);
        tick;
        chk("bp_drain", out_Valid, 0);

        // flush with the pipe full, then flush colliding with an accept
        in_Ready = 1'b0;
        set_op(0, 2'b00, 0, 5'd1, 4'd0, 32'd0, 32'h1, 0);
        in_Valid = 1'b1;
        tick;
        set_op(0, 2'b00, 0, 5'd2, 4'd0, 32'd0, 32'h1, 0);
        tick;
        chk("fl_full_v", out_Valid, 1);
        chk("fl_full_rdy", out_Ready, 0);
        set_op(0, 2'b00, 0, 5'd3, 4'd0, 32'd0, 32'h1, 0);
        in_Flush = 1'b1;
        tick;
        in_Flush = 1'b0;
        in_Valid = 1'b0;
        chk("fl_v", out_Valid, 0);
        chk("fl_rdy", out_Ready, 1);
        in_Ready = 1'b1;
        hits = 0;
        for (int i = 0; i < 4; i++) begin tick; hits += int'(out_Valid); end
        chk("fl_none", hits, 0);
        set_op(0, 2'b00, 0, 5'd4, 4'd0, 32'd0, 32'h1, 0);
        in_Valid = 1'b1;
        in_Flush = 1'b1;
        #1;
        chk("fl_acc_rdy", out_Ready, 1);
        tick;
        in_Valid = 1'b0;
        in_Flush = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin hits += int'(out_Valid); tick; end
        chk("fl_acc_drop", hits, 0);

        // asynchronous reset while a result is held at the output
        in_Ready = 1'b0;
        set_op(0, 2'b11, 0, 5'd0, 4'd0, 32'd0, 32'h3, 1);
        in_Valid = 1'b1;
        tick;
        set_op(0, 2'b00, 0, 5'd5, 4'd0, 32'd0, 32'h1, 0);
        tick;
        in_Valid = 1'b0;
        chk("ar_pre_v", out_Valid, 1);
        chk("ar_pre_r", out_Result, 32'h8000_0001);
        #2;
        in_Rst_N = 1'b0;
        #1;
        chk("ar_v", out_Valid, 0);
        chk("ar_r", out_Result, 0);
        chk("ar_c", out_Carry, 0);
        tick;
        in_Rst_N = 1'b1;
        in_Ready = 1'b1;
        hits = 0;
        for (int i = 0; i < 3; i++) begin tick; hits += int'(out_Valid); end
        chk("ar_none", hits, 0);
        run_op("post_rst", 0, 2'b01, 0, 5'd4, 4'd0, 32'h0, 32'hF000_0008, 0, 32'h0F00_0000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
